// File: rtl/poly_control_bank_pkg.sv
// Shared types and constants for the polymorphic control bank.
// Contents: register index enum, CRC handshake state enum, bit positions of
// the CRC_CTRL and STATUS registers, and the default data width.
package POLI_types_pkg;

  localparam int unsigned WORD_SIZE = 32;

  typedef enum logic [2:0] {
    REG_CRC_IN      = 3'd0,
    REG_CRC_CTRL    = 3'd1,
    REG_CRC_ORIENT  = 3'd2,
    REG_CRC_RESULT  = 3'd3,
    REG_STATUS      = 3'd4,
    REG_GATE_AB     = 3'd5,
    REG_GATE_ORIENT = 3'd6,
    REG_GATE_OUT    = 3'd7
  } regsel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } crc_state_t;

  // CRC_CTRL bit positions
  localparam int unsigned CTRL_RESET_BIT   = 0;
  localparam int unsigned CTRL_START_BIT   = 1;
  localparam int unsigned CTRL_AUTO_BIT    = 2;
  localparam int unsigned CTRL_IE_DONE_BIT = 3;
  localparam int unsigned CTRL_IE_ERR_BIT  = 4;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_OVERRUN_BIT = 2;
  localparam int unsigned STAT_TIMEOUT_BIT = 3;

endpackage

// File: rtl/poly_control_bank_crc_handshake_fsm.sv
// CRC engine handshake: IDLE -> ISSUE (crc_start pulse) -> WAIT (until
// crc_ready or timeout). Generates the crc_reset pulse for both soft reset
// and timeout abort, and captures the CRC result on completion.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start_req           start request (already merged from CTRL/auto-start)
//   i_soft_reset          CRC_CTRL.reset write; wins over everything else
//   i_crc_ready           CRC completion level
//   i_crc_data_out        CRC result from the engine
//   o_crc_start           one-cycle start pulse (high while in ISSUE)
//   o_crc_reset           one-cycle registered reset pulse
//   o_busy                state != IDLE
//   o_result              captured CRC result
//   o_done_set, o_timeout_set, o_overrun_set  one-cycle sticky-bit set events
module crc_handshake_fsm #(
  parameter int unsigned WORD_SIZE      = POLI_types_pkg::WORD_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start_req,
  input  logic                 i_soft_reset,
  input  logic                 i_crc_ready,
  input  logic [WORD_SIZE-1:0] i_crc_data_out,
  output logic                 o_crc_start,
  output logic                 o_crc_reset,
  output logic                 o_busy,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_done_set,
  output logic                 o_timeout_set,
  output logic                 o_overrun_set
);
  import POLI_types_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  crc_state_t           r_state;
  crc_state_t           w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 r_crc_reset;
  logic                 w_capture;
  logic [WORD_SIZE-1:0] r_result;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_crc_reset <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_crc_reset <= i_soft_reset | o_timeout_set;
      if (w_capture) r_result <= i_crc_data_out;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_cnt_next    = r_cnt;
    w_capture     = 1'b0;
    o_done_set    = 1'b0;
    o_timeout_set = 1'b0;
    o_overrun_set = 1'b0;
    o_crc_start   = (r_state == ISSUE);
    // Soft reset drops any concurrent start and suppresses overrun.
    if (i_soft_reset) begin
      w_next_state = IDLE;
    end else begin
      if (i_start_req && (r_state != IDLE)) o_overrun_set = 1'b1;
      case (r_state)
        IDLE: begin
          if (i_start_req) w_next_state = ISSUE;
        end
        ISSUE: begin
          w_cnt_next   = '0;
          w_next_state = WAIT;
        end
        WAIT: begin
          w_cnt_next = r_cnt + 1'b1;
          // Ready on the last allowed cycle still completes normally.
          if (i_crc_ready) begin
            w_capture    = 1'b1;
            o_done_set   = 1'b1;
            w_next_state = IDLE;
          end else if (r_cnt == LAST_CNT) begin
            o_timeout_set = 1'b1;
            w_next_state  = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  assign o_crc_reset = r_crc_reset;
  assign o_busy      = (r_state != IDLE);
  assign o_result    = r_result;

endmodule

// File: rtl/poly_control_bank.sv
// APB-facing register bank driving one CRC32 engine and NUM_GATES
// polymorphic gate channels.
// Ports:
//   CLK, nRST                       clock, synchronous active-low reset
//   write_enable, register_select,  APB write strobe / register index /
//   write_data, read_data           write data / combinational read mux
//   crc_data_in, crc_orient         CRC operand and orientation registers
//   crc_reset, crc_start            one-cycle CRC control pulses
//   crc_data_out, crc_ready         CRC result and completion level
//   gate_a, gate_b, gate_orient     per-channel gate inputs and mode
//   gate_out                        raw (asynchronous) gate outputs
//   irq                             level interrupt
module poly_control_bank #(
  parameter int unsigned WORD_SIZE      = POLI_types_pkg::WORD_SIZE,
  parameter int unsigned NUM_GATES      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 write_enable,
  input  logic [2:0]           register_select,
  input  logic [WORD_SIZE-1:0] write_data,
  output logic [WORD_SIZE-1:0] read_data,
  output logic [WORD_SIZE-1:0] crc_data_in,
  output logic [WORD_SIZE-1:0] crc_orient,
  output logic                 crc_reset,
  output logic                 crc_start,
  input  logic [WORD_SIZE-1:0] crc_data_out,
  input  logic                 crc_ready,
  output logic [NUM_GATES-1:0] gate_a,
  output logic [NUM_GATES-1:0] gate_b,
  output logic [NUM_GATES-1:0] gate_orient,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic                 irq
);
  import POLI_types_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WORD_SIZE-1:0] r_crc_in;
  logic [WORD_SIZE-1:0] r_crc_orient;
  logic                 r_auto_start;
  logic                 r_ie_done;
  logic                 r_ie_err;
  logic                 r_done;
  logic                 r_overrun;
  logic                 r_timeout;
  logic [NUM_GATES-1:0] r_gate_a;
  logic [NUM_GATES-1:0] r_gate_b;
  logic [NUM_GATES-1:0] r_gate_orient;
  logic [NUM_GATES-1:0] r_gout_meta;
  logic [NUM_GATES-1:0] r_gout_sync;

  regsel_t              w_sel;
  logic                 w_wr_in;
  logic                 w_wr_ctrl;
  logic                 w_wr_status;
  logic                 w_start_req;
  logic                 w_soft_reset;
  logic                 w_busy;
  logic                 w_done_set;
  logic                 w_timeout_set;
  logic                 w_overrun_set;
  logic [WORD_SIZE-1:0] w_result;

  assign w_sel        = regsel_t'(register_select);
  assign w_wr_in      = write_enable && (w_sel == REG_CRC_IN);
  assign w_wr_ctrl    = write_enable && (w_sel == REG_CRC_CTRL);
  assign w_wr_status  = write_enable && (w_sel == REG_STATUS);
  assign w_soft_reset = w_wr_ctrl & write_data[CTRL_RESET_BIT];
  // Explicit start and auto-start on a CRC_IN write merge into one request.
  assign w_start_req  = (w_wr_ctrl & write_data[CTRL_START_BIT]) |
                        (w_wr_in & r_auto_start);

  crc_handshake_fsm #(
    .WORD_SIZE      (WORD_SIZE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_fsm (
    .i_clk          (CLK),
    .i_rst_n        (nRST),
    .i_start_req    (w_start_req),
    .i_soft_reset   (w_soft_reset),
    .i_crc_ready    (crc_ready),
    .i_crc_data_out (crc_data_out),
    .o_crc_start    (crc_start),
    .o_crc_reset    (crc_reset),
    .o_busy         (w_busy),
    .o_result       (w_result),
    .o_done_set     (w_done_set),
    .o_timeout_set  (w_timeout_set),
    .o_overrun_set  (w_overrun_set)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_crc_in      <= '0;
      r_crc_orient  <= '0;
      r_auto_start  <= 1'b0;
      r_ie_done     <= 1'b0;
      r_ie_err      <= 1'b0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout     <= 1'b0;
      r_gate_a      <= '0;
      r_gate_b      <= '0;
      r_gate_orient <= '0;
      r_gout_meta   <= '0;
      r_gout_sync   <= '0;
    end else begin
      if (w_wr_in) r_crc_in <= write_data;
      if (write_enable && (w_sel == REG_CRC_ORIENT)) r_crc_orient <= write_data;
      if (w_wr_ctrl) begin
        r_auto_start <= write_data[CTRL_AUTO_BIT];
        r_ie_done    <= write_data[CTRL_IE_DONE_BIT];
        r_ie_err     <= write_data[CTRL_IE_ERR_BIT];
      end
      if (write_enable && (w_sel == REG_GATE_AB)) begin
        r_gate_a <= write_data[NUM_GATES-1:0];
        r_gate_b <= write_data[2*NUM_GATES-1:NUM_GATES];
      end
      if (write_enable && (w_sel == REG_GATE_ORIENT)) r_gate_orient <= write_data[NUM_GATES-1:0];
      // Sticky bits: a set event in the same cycle as W1C wins.
      r_done    <= w_done_set    | (r_done    & ~(w_wr_status & write_data[STAT_DONE_BIT]));
      r_overrun <= w_overrun_set | (r_overrun & ~(w_wr_status & write_data[STAT_OVERRUN_BIT]));
      r_timeout <= w_timeout_set | (r_timeout & ~(w_wr_status & write_data[STAT_TIMEOUT_BIT]));
      // Gate outputs come from combinational loops; synchronise before use.
      r_gout_meta <= gate_out;
      r_gout_sync <= r_gout_meta;
    end
  end

  always_comb begin
    read_data = '0;
    case (w_sel)
      REG_CRC_IN:     read_data = r_crc_in;
      REG_CRC_CTRL: begin
        read_data[CTRL_AUTO_BIT]    = r_auto_start;
        read_data[CTRL_IE_DONE_BIT] = r_ie_done;
        read_data[CTRL_IE_ERR_BIT]  = r_ie_err;
      end
      REG_CRC_ORIENT: read_data = r_crc_orient;
      REG_CRC_RESULT: read_data = w_result;
      REG_STATUS: begin
        read_data[STAT_BUSY_BIT]    = w_busy;
        read_data[STAT_DONE_BIT]    = r_done;
        read_data[STAT_OVERRUN_BIT] = r_overrun;
        read_data[STAT_TIMEOUT_BIT] = r_timeout;
      end
      REG_GATE_AB: begin
        read_data[NUM_GATES-1:0]           = r_gate_a;
        read_data[2*NUM_GATES-1:NUM_GATES] = r_gate_b;
      end
      REG_GATE_ORIENT: read_data[NUM_GATES-1:0] = r_gate_orient;
      REG_GATE_OUT:    read_data[NUM_GATES-1:0] = r_gout_sync;
      default:         read_data = '0;
    endcase
  end

  assign crc_data_in = r_crc_in;
  assign crc_orient  = r_crc_orient;
  assign gate_a      = r_gate_a;
  assign gate_b      = r_gate_b;
  assign gate_orient = r_gate_orient;
  assign irq         = (r_done & r_ie_done) | ((r_overrun | r_timeout) & r_ie_err);

endmodule
